// File: rtl/egd_encoder.sv
// egd_encoder -- Exp-Golomb (ue(v)/se(v)) encoder and MSB-first bit packer.
//
// Each accepted value is mapped to a codeNum and turned into its codeword
// in the same cycle. The codeword is then appended to a 2*OUT_W-bit
// accumulator. Complete OUT_W-bit words leave on a valid/ready stream with
// the first stream bit in the MSB. A flush pads the pending bits with zeros
// up to a word boundary and tags the final padded word with out_last.
//
// Ports:
//   wb_clk_i    clock; all state changes on the rising edge
//   wb_rst_i    asynchronous active-low reset
//   in_valid    input value valid
//   in_ready    encoder can take a value and/or a flush this cycle
//   in_value    value; unsigned for ue, two's complement for se
//   in_signed   1 = se(v) mapping, 0 = ue(v) mapping
//   flush_i     pad pending bits to a word boundary (qualified by in_ready)
//   out_valid   out_data holds a complete word
//   out_ready   downstream takes the word
//   out_data    packed word, earliest bit in the MSB
//   out_last    final word of a flush
//   code_len_o  length of the most recently accepted codeword
//   busy        bits pending or flush in progress
//   word_cnt    number of words popped, wraps mod 2^16
module egd_encoder #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value,
  input  logic              in_signed,
  input  logic              flush_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic [4:0]        code_len_o,
  output logic              busy,
  output logic [15:0]       word_cnt
);

  localparam int ACC_W  = 2 * OUT_W;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int NUM_W  = DATA_W + 2;

  // State
  logic [ACC_W-1:0]  acc;
  logic [FILL_W-1:0] fill;
  logic              flush_pending;

  // Next-state values
  logic [ACC_W-1:0]  acc_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic              flush_pending_nxt;
  logic [15:0]       word_cnt_nxt;
  logic [4:0]        code_len_nxt;

  // Codeword datapath
  logic [NUM_W-1:0]  value_ext;
  logic              value_pos;
  logic [NUM_W-1:0]  code_num;
  logic [NUM_W-1:0]  code_m;
  logic [4:0]        lead_pos;
  logic [4:0]        code_len;
  logic [FILL_W-1:0] shamt;
  logic [ACC_W-1:0]  code_aligned;

  logic accept;
  logic flush_go;
  logic pop;

  assign in_ready = (fill <= FILL_W'(OUT_W - 1)) && !flush_pending;
  assign accept   = in_valid && in_ready;
  assign flush_go = flush_i && in_ready;
  // out_valid mirrors fill >= OUT_W, so a pop can never coincide with an
  // accept (which needs fill < OUT_W).
  assign pop      = out_valid && out_ready;

  assign out_data = acc[ACC_W-1 -: OUT_W];
  assign busy     = (fill != '0) || flush_pending;

  // codeNum mapping. The two extra bits hold 2*|v| for the most negative
  // se input (-2^(DATA_W-1) maps to 2^DATA_W).
  always_comb begin
    value_ext = in_signed ? {{2{in_value[DATA_W-1]}}, in_value}
                          : {2'b00, in_value};
    value_pos = !in_value[DATA_W-1] && (in_value != '0);
    if (!in_signed)
      code_num = value_ext;
    else if (value_pos)
      code_num = (value_ext << 1) - NUM_W'(1);
    else
      code_num = NUM_W'(0) - (value_ext << 1);
    code_m = code_num + NUM_W'(1);
  end

  // N = floor(log2 M). The codeword is M zero-extended to 2N+1 bits, so the
  // N leading zeros come for free from the alignment shift below.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    lead_pos = '0;
    for (int i = 0; i < NUM_W; i++) begin
      if (code_m[i]) lead_pos = 5'(i);
    end
    code_len     = (lead_pos << 1) + 5'd1;
    shamt        = FILL_W'(ACC_W) - fill - FILL_W'(code_len);
    code_aligned = ACC_W'(code_m) << shamt;
  end

  always_comb begin
    acc_nxt           = acc;
    fill_nxt          = fill;
    flush_pending_nxt = flush_pending;
    word_cnt_nxt      = word_cnt;
    code_len_nxt      = code_len_o;

    if (accept) begin
      acc_nxt      = acc | code_aligned;
      fill_nxt     = fill + FILL_W'(code_len);
      code_len_nxt = code_len;
    end

    // Round up to a word boundary after any same-cycle append. Fill never
    // exceeds ACC_W, so the result is 0, OUT_W or ACC_W.
    if (flush_go) begin
      if (fill_nxt == '0)
        fill_nxt = '0;
      else if (fill_nxt <= FILL_W'(OUT_W))
        fill_nxt = FILL_W'(OUT_W);
      else
        fill_nxt = FILL_W'(ACC_W);
      flush_pending_nxt = (fill_nxt != '0);
    end

    if (pop) begin
      acc_nxt      = acc << OUT_W;
      fill_nxt     = fill - FILL_W'(OUT_W);
      word_cnt_nxt = word_cnt + 16'd1;
      if (fill_nxt == '0) flush_pending_nxt = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      acc           <= '0;
      fill          <= '0;
      flush_pending <= 1'b0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      code_len_o    <= '0;
      word_cnt      <= '0;
    end else begin
      acc           <= acc_nxt;
      fill          <= fill_nxt;
      flush_pending <= flush_pending_nxt;
      out_valid     <= (fill_nxt >= FILL_W'(OUT_W));
      out_last      <= flush_pending_nxt && (fill_nxt == FILL_W'(OUT_W));
      code_len_o    <= code_len_nxt;
      word_cnt      <= word_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_egd_encoder.sv
// tb_egd_encoder -- self-checking bench for egd_encoder.
// The reference model keeps the stream as a queue of bits built from the
// Exp-Golomb rules with plain integer arithmetic, and cuts it into expected
// 16-bit words that a monitor compares against every popped word.
module tb_egd_encoder;

  logic        wb_clk_i  = 1'b0;
  logic        wb_rst_i  = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [7:0]  in_value  = '0;
  logic        in_signed = 1'b0;
  logic        flush_i   = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_last;
  logic [4:0]  code_len_o;
  logic        busy;
  logic [15:0] word_cnt;

  egd_encoder #(.DATA_W(8), .OUT_W(16)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .in_signed  (in_signed),
    .flush_i    (flush_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .code_len_o (code_len_o),
    .busy       (busy),
    .word_cnt   (word_cnt)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } word_t;

  word_t exp_q[$];
  bit    bit_q[$];
  int    errors  = 0;
  int    checks  = 0;
  int    pop_cnt = 0;
  bit    rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Exp-Golomb codeword from first principles: M = codeNum+1, len = 2N+1.
  function automatic void model_code(input int v, input bit s, output int len, output int m);
    int cn;
    int sv;
    int n;
    if (!s) cn = v;
    else begin
      sv = (v >= 128) ? v - 256 : v;
      cn = (sv > 0) ? 2 * sv - 1 : -2 * sv;
    end
    m = cn + 1;
    n = 0;
    while ((m >> (n + 1)) != 0) n++;
    len = 2 * n + 1;
  endfunction

  // Cut complete words off the bit queue; a flush pads with zeros first and
  // tags the word that empties the queue as last.
  function automatic void model_extract(input bit flush);
    word_t w;
    if (flush) while ((bit_q.size() % 16) != 0) bit_q.push_back(1'b0);
    while (bit_q.size() >= 16) begin
      for (int i = 15; i >= 0; i--) w.data[i] = bit_q.pop_front();
      w.last = flush && (bit_q.size() == 0);
      exp_q.push_back(w);
    end
  endfunction

  task automatic cycle();
    @(posedge wb_clk_i);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present a value and/or flush once in_ready is high; it is taken at the
  // next rising edge.
  task automatic send(input int v, input bit s, input bit f, input bit has_val);
    int guard;
    int len;
    int m;
    guard = 0;
    while (!in_ready && guard < 300) begin
      cycle();
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
      return;
    end
    in_valid  = has_val;
    in_value  = v[7:0];
    in_signed = s;
    flush_i   = f;
    len = 0;
    if (has_val) begin
      model_code(v, s, len, m);
      for (int i = len - 1; i >= 0; i--) bit_q.push_back(bit'((m >> i) & 1));
    end
    model_extract(f);
    cycle();
    in_valid = 1'b0;
    flush_i  = 1'b0;
    if (has_val) check("code_len", code_len_o, len);
  endtask

  task automatic drain();
    int guard;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 500) begin
      cycle();
      guard++;
    end
    check("drain_done", exp_q.size(), 0);
    check("drain_word_cnt", word_cnt, pop_cnt & 16'hFFFF);
  endtask

  // Popped-word monitor, sampling on the falling edge.
  always @(negedge wb_clk_i) begin
    if (wb_rst_i && out_valid && out_ready) begin
      check("word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        word_t w;
        w = exp_q.pop_front();
        check("out_data", out_data, w.data);
        check("out_last", out_last, w.last);
        pop_cnt++;
      end
    end
  end

  initial begin
    int v;
    bit s;
    bit f;
    bit hv;

    // Reset state
    cycle();
    cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_code_len", code_len_o, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    wb_rst_i = 1'b1;
    cycle();

    // Word packing: sixteen ue 0 -> 0xFFFF
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(0, 0, 0, 1);
    drain();
    check("pack_word_cnt", word_cnt, 1);
    check("pack_code_len", code_len_o, 1);

    // Flush padding: ue 3 -> 0x2000 last
    send(3, 0, 0, 1);
    send(0, 0, 1, 0);
    drain();
    check("flush_busy", busy, 0);

    // Signed mapping: se -1, se +1 -> 0x6800 last
    send(8'hFF, 1, 0, 1);
    send(1, 1, 0, 1);
    send(0, 0, 1, 0);
    drain();

    // Overflow with backpressure: 15 x ue 0 then ue 255
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(0, 0, 0, 1);
    check("ovf_in_ready_fill15", in_ready, 1);
    send(255, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 16'hFFFE);
      check("bp_out_last", out_last, 0);
      cycle();
    end
    drain();

    // Long signed code: se -128 -> 0x0080, 0x8000 (last)
    send(128, 1, 0, 1);
    check("se128_len", code_len_o, 17);
    send(0, 0, 1, 0);
    drain();
    check("se128_busy", busy, 0);

    // Reset mid-operation discards pending bits
    for (int i = 0; i < 10; i++) send(0, 0, 0, 1);
    check("pre_rst_busy", busy, 1);
    wb_rst_i = 1'b0;
    bit_q.delete();
    exp_q.delete();
    pop_cnt = 0;
    cycle();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_word_cnt", word_cnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    wb_rst_i = 1'b1;
    cycle();
    send(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle();
    check("post_rst_flush_word_cnt", word_cnt, 0);
    check("post_rst_flush_busy", busy, 0);
    check("post_rst_out_valid", out_valid, 0);

    // Randomized traffic with random backpressure and flushes
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      v  = $urandom_range(0, 255);
      s  = 1'($urandom_range(0, 1));
      f  = ($urandom_range(0, 7) == 0);
      hv = f ? 1'($urandom_range(0, 1)) : 1'b1;
      send(v, s, f, hv);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    send(0, 0, 1, 0);
    drain();
    check("rand_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/egd_encoder.md
Name: egd_encoder

Overview:
- Exp-Golomb encoder (ue(v)/se(v)) and bit packer; counterpart of the exp-Golomb decoder.
- Accepts one 8-bit syntax value per handshake and computes its codeword.
- Appends codewords MSB-first to a bit accumulator and emits packed 16-bit words on a valid/ready stream.
- Used to generate test bitstreams for the decoder in the same user project area.

Parameters:
- DATA_W, 8: input value width. Constraint: 2*DATA_W+1 <= OUT_W+1.
- OUT_W, 16: output word width. Accumulator width is 2*OUT_W.

Ports:
- wb_clk_i  in  1  clock; all logic is on the rising edge.
- wb_rst_i  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input value valid.
- in_ready  out  1  encoder can accept a value or a flush.
- in_value  in  DATA_W  value; unsigned for ue, two's complement for se.
- in_signed  in  1  1 = se(v) mapping, 0 = ue(v).
- flush_i  in  1  pad the pending bits to a word boundary; qualified by in_ready.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  OUT_W  packed bits; first bit of the stream is in the MSB.
- out_last  out  1  marks the final word of a flush.
- code_len_o  out  5  length of the last accepted codeword.
- busy  out  1  fill != 0 or flush pending.
- word_cnt  out  16  count of words popped; wraps mod 2^16.

Behaviour:
- Reset (async assert, sync release): accumulator=0, fill=0, flush_pending=0, out_valid=0, out_data=0, out_last=0, code_len_o=0, word_cnt=0, busy=0, in_ready=1.
- Mapping:
  - ue: codeNum = in_value.
  - se: v>0 gives codeNum = 2v-1; v<=0 gives codeNum = -2v.
  - Compute codeNum in DATA_W+2 bits; se -128 gives 256.
- Codeword: M = codeNum+1; N = floor(log2 M); codeword = N zeros followed by the N+1 bits of M; len = 2N+1 (1..17).
- Codeword computation is combinational in the acceptance cycle.
- in_ready = (fill <= OUT_W-1) && !flush_pending.
- Accept: in_valid && in_ready.
  - acc |= code << (2*OUT_W - fill - len); fill += len; code_len_o <= len.
  - fill <= 15+17 = 32, so the accumulator never overflows.
- Flush: flush_i && in_ready.
  - If in_valid is also high, the value is appended first in the same cycle.
  - Then fill is rounded up to a multiple of OUT_W; pad bits are 0.
  - flush_pending=1 if the rounded fill > 0.
  - A flush with resulting fill 0 does nothing and produces no out_last.
- Output:
  - out_valid = (fill >= OUT_W), registered, visible the cycle after the append.
  - out_data = acc[2*OUT_W-1 -: OUT_W].
  - out_last = flush_pending && fill == OUT_W.
- Pop (out_valid && out_ready): acc <<= OUT_W; fill -= OUT_W; word_cnt++; flush_pending cleared when fill becomes 0.
- Accept and pop are never in the same cycle, because in_ready requires fill < OUT_W.
- Backpressure: out_data, out_last and out_valid hold stable while out_ready=0.
- Latency: a codeword that completes a word produces out_valid 1 cycle after acceptance.
- Reset mid-operation discards all pending bits; no word is emitted for them.
- Throughput: one value per cycle while fill < 16; one word per cycle while draining.

Test Plan:
- Word packing: sixteen ue 0 (codeword "1") back-to-back, out_ready=1 -> one word 0xFFFF, out_last=0, word_cnt=1, code_len_o=1.
- Flush padding: ue 3 (00100) then flush_i -> word 0x2000 with out_last=1; busy=0 afterwards.
- Signed mapping: se -1 (011), se +1 (010), then flush -> word 0x6800, out_last=1.
- Overflow and backpressure:
  - Stimulus: fifteen ue 0, then ue 255 (len 17, fill reaches 32), with out_ready held 0 for 5 cycles.
  - Response: in_ready=0 throughout, out_data stable at 0xFFFE; after release, words 0xFFFE then 0x0100.
- Long signed code: se -128 (codeNum 256, len 17), then flush -> code_len_o=17; words 0x0080 then 0x8000, out_last only on the second word.
- Reset mid-operation: accept ue 0 x10, assert wb_rst_i low for 1 cycle -> out_valid=0, word_cnt=0, busy=0, in_ready=1; a following flush emits nothing.
